// File: rtl/mem_cache_ctrl_pkg.sv
// Shared definitions for the memory-stage cache controller: access codes and FSM states.
package mem_pkg;

    localparam logic [1:0] ROW_NONE  = 2'b00;
    localparam logic [1:0] ROW_READ  = 2'b01;
    localparam logic [1:0] ROW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_cache_ctrl_line_array.sv
// Direct-mapped line storage: one valid bit, tag and data word per line.
// Reads are combinational; writes land on the rising edge. Only the valid
// bits are cleared by reset, so tags and data may hold stale contents.
module cache_line_array #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_set_valid
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_bits;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] words [LINES];

    assign rd_valid = valid_bits[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

    // Valid bits: cleared on reset, updated by a line write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= wr_set_valid;
        end
    end

    // Tag and data storage: never reset, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_cache_ctrl.sv
// MEM-stage controller: direct-mapped write-through, no-write-allocate cache
// with a stalling req/ack miss handler and hit/miss statistics counters.
//
// state   | meaning
// IDLE    | decode row_i; read hits served combinationally
// RD_MISS | read request outstanding; line filled on ack
// WR_MEM  | write-through request outstanding; hitting line updated on ack
module mem_cache_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        row_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o,
    output logic              hit_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_next;

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              line_hit;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;
    logic              hit_inc;
    logic              miss_inc;

    assign index    = address_i[IDX_W+OFF_W-1:OFF_W];
    assign tag      = address_i[ADDR_W-1:IDX_W+OFF_W];
    assign line_hit = line_valid && (line_tag == tag);

    // Since the pipeline holds address_i stable while stalled, the read index
    // doubles as the fill/update index at the ack edge.
    cache_line_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (index),
        .rd_valid    (line_valid),
        .rd_tag      (line_tag),
        .rd_data     (line_data),
        .wr_en       (arr_we),
        .wr_index    (index),
        .wr_tag      (tag),
        .wr_data     (arr_wdata),
        .wr_set_valid(1'b1)
    );

    // State register; reset aborts any outstanding transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Access decode, memory-port drive and next-state selection.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        hit_o       = 1'b0;
        data_o      = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        arr_we      = 1'b0;
        arr_wdata   = mem_rdata_i;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (row_i == ROW_READ) begin
                    if (line_hit) begin
                        hit_o   = 1'b1;
                        data_o  = line_data;
                        hit_inc = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        miss_inc   = 1'b1;
                        state_next = RD_MISS;
                    end
                end else if (row_i == ROW_WRITE) begin
                    stall_o    = 1'b1;
                    state_next = WR_MEM;
                end
            end
            RD_MISS: begin
                mem_req_o  = 1'b1;
                mem_addr_o = address_i & ALIGN_MASK;
                if (mem_ack_i) begin
                    data_o     = mem_rdata_i;
                    arr_we     = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            WR_MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = address_i & ALIGN_MASK;
                mem_wdata_o = data_i;
                arr_wdata   = data_i;
                if (mem_ack_i) begin
                    arr_we     = line_hit;
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Statistics counters, wrapping naturally at 2**CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            if (hit_inc) begin
                hit_count_o <= hit_count_o + CNT_ONE;
            end
            if (miss_inc) begin
                miss_count_o <= miss_count_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Self-checking bench for mem_cache_ctrl: directed scenarios plus randomized
// accesses scored against a behavioural cache/backing-memory model.
module tb_mem_cache_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 32;
    localparam int LINES  = 16;

    logic              clk;
    logic              reset;
    logic [1:0]        row_i;
    logic [ADDR_W-1:0] address_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              stall_o;
    logic              hit_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [CNT_W-1:0]  hit_count_o;
    logic [CNT_W-1:0]  miss_count_o;

    int checks = 0;
    int errors = 0;

    mem_cache_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .row_i(row_i), .address_i(address_i),
        .data_i(data_i), .data_o(data_o), .stall_o(stall_o), .hit_o(hit_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cache lines, backing memory by word address, statistics.
    bit              m_valid [LINES];
    int unsigned     m_tag   [LINES];
    logic [31:0]     m_data  [LINES];
    logic [31:0]     bmem    [int unsigned];
    int unsigned     m_hits;
    int unsigned     m_misses;

    typedef struct {
        int          stall;
        logic [31:0] data;
        logic        hit;
        bit          req_seen;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          unstable;
        bit          timeout;
        bit          exp_hit;
        logic [31:0] exp_data;
        bit          exp_mem;
    } acc_t;

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step(input logic [1:0] row, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              output bit exp_hit, output logic [31:0] exp_data,
                              output bit exp_mem);
        int unsigned idx = (addr / 4) % LINES;
        int unsigned tg  = addr / (4 * LINES);
        int unsigned wa  = addr / 4;
        bit present = m_valid[idx] && (m_tag[idx] == tg);
        exp_hit  = 1'b0;
        exp_data = '0;
        exp_mem  = 1'b0;
        if (row == 2'b01) begin
            if (present) begin
                exp_hit  = 1'b1;
                exp_data = m_data[idx];
                m_hits++;
            end else begin
                exp_mem      = 1'b1;
                exp_data     = rdata;
                m_misses++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = rdata;
                bmem[wa]     = rdata;
            end
        end else if (row == 2'b10) begin
            exp_mem  = 1'b1;
            bmem[wa] = wdata;
            if (present) m_data[idx] = wdata;
        end
    endtask

    // Present one access, play the backing memory (ack `delay` cycles after the
    // request rises), and record what the DUT showed along the way.
    task automatic do_access(input logic [1:0] row, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int delay, output acc_t r);
        int req_cycles = 0;
        bit finished = 1'b0;
        r = '{default: '0};
        row_i       = row;
        address_i   = addr;
        data_i      = wdata;
        mem_rdata_i = rdata;
        mem_ack_i   = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!r.req_seen) begin
                    r.we = mem_we_o; r.addr = mem_addr_o; r.wdata = mem_wdata_o;
                end else if (r.we !== mem_we_o || r.addr !== mem_addr_o || r.wdata !== mem_wdata_o) begin
                    r.unstable = 1'b1;
                end
                r.req_seen = 1'b1;
                req_cycles++;
            end
            if (stall_o === 1'b0) begin
                r.data = data_o;
                r.hit  = hit_o;
                finished = 1'b1;
                break;
            end
            r.stall++;
            @(posedge clk); #1;
            mem_ack_i = (req_cycles == delay);
        end
        r.timeout = !finished;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        row_i     = ROW_NONE;
        model_step(row, addr, wdata, rdata, r.exp_hit, r.exp_data, r.exp_mem);
    endtask

    task automatic test_reset();
        reset = 1'b1; row_i = ROW_NONE; address_i = 32'h40; data_i = 32'hA5A5A5A5;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        checks++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count_o, miss_count_o); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (data_o !== 32'h0 || hit_o !== 1'b0) begin errors++; $display("FAIL idle_none got data %h hit %b want 0/0", data_o, hit_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        acc_t r;
        do_access(ROW_READ, 32'h40, 32'h0, 32'hDEADBEEF, 3, r);
        checks++; if (r.timeout) begin errors++; $display("FAIL cold_timeout got timeout want completion"); end
        checks++; if (r.stall !== 4) begin errors++; $display("FAIL cold_stall got %0d want 4", r.stall); end
        checks++; if (r.data !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_data got %h want deadbeef", r.data); end
        checks++; if (r.we !== 1'b0 || r.addr !== 32'h40) begin errors++; $display("FAIL cold_req got we %b addr %h want 0/40", r.we, r.addr); end
        checks++; if (miss_count_o !== 32'd1) begin errors++; $display("FAIL cold_miss_count got %0d want 1", miss_count_o); end
    endtask

    task automatic test_read_hit();
        acc_t r;
        do_access(ROW_READ, 32'h40, 32'h0, 32'h0, 3, r);
        checks++; if (r.stall !== 0 || r.hit !== 1'b1) begin errors++; $display("FAIL hit_stall got stall %0d hit %b want 0/1", r.stall, r.hit); end
        checks++; if (r.data !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data got %h want deadbeef", r.data); end
        checks++; if (r.req_seen) begin errors++; $display("FAIL hit_no_req got req %b want 0", r.req_seen); end
        checks++; if (hit_count_o !== 32'd1) begin errors++; $display("FAIL hit_count got %0d want 1", hit_count_o); end
    endtask

    task automatic test_write_hit();
        acc_t r;
        do_access(ROW_WRITE, 32'h40, 32'h12345678, 32'h0, 1, r);
        checks++; if (r.stall !== 2) begin errors++; $display("FAIL wr_stall got %0d want 2", r.stall); end
        checks++; if (r.we !== 1'b1 || r.addr !== 32'h40 || r.wdata !== 32'h12345678) begin errors++; $display("FAIL wr_req got we %b addr %h wdata %h want 1/40/12345678", r.we, r.addr, r.wdata); end
        do_access(ROW_READ, 32'h40, 32'h0, 32'h0, 1, r);
        checks++; if (r.stall !== 0 || r.data !== 32'h12345678) begin errors++; $display("FAIL wr_hit_read got stall %0d data %h want 0/12345678", r.stall, r.data); end
    endtask

    task automatic test_write_miss();
        acc_t r;
        do_access(ROW_WRITE, 32'h80, 32'hAABBCCDD, 32'h0, 2, r);
        checks++; if (r.stall !== 3 || r.addr !== 32'h80) begin errors++; $display("FAIL wmiss_write got stall %0d addr %h want 3/80", r.stall, r.addr); end
        do_access(ROW_READ, 32'h80, 32'h0, 32'hAABBCCDD, 1, r);
        checks++; if (r.stall !== 2 || r.hit !== 1'b0) begin errors++; $display("FAIL wmiss_alloc got stall %0d hit %b want 2/0", r.stall, r.hit); end
        checks++; if (r.we !== 1'b0 || r.addr !== 32'h80) begin errors++; $display("FAIL wmiss_req got we %b addr %h want 0/80", r.we, r.addr); end
        checks++; if (miss_count_o !== m_misses) begin errors++; $display("FAIL wmiss_count got %0d want %0d", miss_count_o, m_misses); end
    endtask

    task automatic test_conflict();
        acc_t r;
        do_access(ROW_READ, 32'h440, 32'h0, 32'h44004400, 1, r);
        checks++; if (r.stall !== 2 || r.data !== 32'h44004400) begin errors++; $display("FAIL conflict_fill got stall %0d data %h want 2/44004400", r.stall, r.data); end
        do_access(ROW_READ, 32'h40, 32'h0, 32'h12345678, 2, r);
        checks++; if (r.stall !== 3 || r.hit !== 1'b0) begin errors++; $display("FAIL conflict_evict got stall %0d hit %b want 3/0", r.stall, r.hit); end
        checks++; if (r.data !== 32'h12345678) begin errors++; $display("FAIL conflict_data got %h want 12345678", r.data); end
    endtask

    task automatic test_ack_ignored();
        row_i = ROW_NONE; mem_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL ack_idle got stall %b req %b want 0/0", stall_o, mem_req_o); end
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b0 || hit_count_o !== m_hits || miss_count_o !== m_misses) begin errors++; $display("FAIL ack_ignored got req %b counts %0d/%0d want 0 %0d/%0d", mem_req_o, hit_count_o, miss_count_o, m_hits, m_misses); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        acc_t r;
        for (int n = 0; n < 150; n++) begin
            int unsigned sel = $urandom_range(0, 9);
            logic [1:0] row = (sel < 5) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11;
            logic [31:0] addr = 32'($urandom_range(0, 2)) * 64 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            logic [31:0] wdata = $urandom;
            int unsigned wa = addr / 4;
            logic [31:0] rdata = bmem.exists(wa) ? bmem[wa] : $urandom;
            int delay = $urandom_range(1, 4);
            do_access(row, addr, wdata, rdata, delay, r);
            checks++; if (r.timeout) begin errors++; $display("FAIL rnd_timeout #%0d got timeout want completion", n); end
            checks++; if (r.stall !== (r.exp_mem ? delay + 1 : 0)) begin errors++; $display("FAIL rnd_stall #%0d got %0d want %0d", n, r.stall, r.exp_mem ? delay + 1 : 0); end
            checks++; if (r.hit !== r.exp_hit) begin errors++; $display("FAIL rnd_hit #%0d got %b want %b", n, r.hit, r.exp_hit); end
            if (row != 2'b10) begin
                checks++; if (r.data !== r.exp_data) begin errors++; $display("FAIL rnd_data #%0d got %h want %h", n, r.data, r.exp_data); end
            end
            checks++; if (r.req_seen !== r.exp_mem) begin errors++; $display("FAIL rnd_req #%0d got %b want %b", n, r.req_seen, r.exp_mem); end
            if (r.exp_mem) begin
                checks++; if (r.we !== (row == 2'b10) || r.addr !== (addr & ~32'h3) || r.unstable) begin errors++; $display("FAIL rnd_req_fields #%0d got we %b addr %h unstable %b want %b %h 0", n, r.we, r.addr, r.unstable, row == 2'b10, addr & ~32'h3); end
                if (row == 2'b10) begin
                    checks++; if (r.wdata !== wdata) begin errors++; $display("FAIL rnd_wdata #%0d got %h want %h", n, r.wdata, wdata); end
                end
            end
            checks++; if (hit_count_o !== m_hits || miss_count_o !== m_misses) begin errors++; $display("FAIL rnd_counts #%0d got %0d/%0d want %0d/%0d", n, hit_count_o, miss_count_o, m_hits, m_misses); end
        end
    endtask

    task automatic test_reset_mid_miss();
        acc_t r;
        row_i = ROW_READ; address_i = 32'h140; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL midrst_pre got req %b want 1", mem_req_o); end
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_drop got req %b want 0", mem_req_o); end
        row_i = ROW_NONE;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        do_access(ROW_READ, 32'h40, 32'h0, 32'h12345678, 2, r);
        checks++; if (r.stall !== 3 || r.hit !== 1'b0) begin errors++; $display("FAIL midrst_miss got stall %0d hit %b want 3/0", r.stall, r.hit); end
        checks++; if (miss_count_o !== 32'd1 || hit_count_o !== 32'd0) begin errors++; $display("FAIL midrst_counts got %0d/%0d want 0/1", hit_count_o, miss_count_o); end
        do_access(ROW_READ, 32'h40, 32'h0, 32'h0, 2, r);
        checks++; if (r.stall !== 0 || r.data !== 32'h12345678 || hit_count_o !== 32'd1) begin errors++; $display("FAIL midrst_refill_hit got stall %0d data %h hits %0d want 0/12345678/1", r.stall, r.data, hit_count_o); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_ack_ignored();
        test_random();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_cache_ctrl.md
# mem_cache_ctrl

Parametrised memory-stage controller that replaces the fixed read/write decode plus 32-bit cache with a configurable direct-mapped, write-through, no-write-allocate cache and a stalling miss handler. It sits in the MEM pipeline stage: it decodes the stage's 2-bit access code, serves read hits in the same cycle, and for misses and writes it stalls the pipeline while it completes a req/ack transaction on the backing-memory port. Hit and miss counters support simulator statistics.

## Interface
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width. Power of two, at least 8.
- IDX_W, 4: index bits. Cache holds 2**IDX_W one-word lines.
- CNT_W, 32: hit/miss counter width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- row_i  in  2  access code: 01 = read, 10 = write; 00 and 11 = no access.
- address_i  in  ADDR_W  byte address. Low log2(DATA_W/8) bits are ignored.
- data_i  in  DATA_W  write data.
- data_o  out  DATA_W  read data.
- stall_o  out  1  pipeline must hold all inputs stable while this is high.
- hit_o  out  1  the current access is a read hit.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  word-aligned address; low offset bits forced to 0.
- mem_wdata_o  out  DATA_W  backing-memory write data.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_rdata_i  in  DATA_W  read data, valid while mem_ack_i is high.
- hit_count_o  out  CNT_W  number of read hits.
- miss_count_o  out  CNT_W  number of read misses.

## Operation
- Address split: off = log2(DATA_W/8) bits; index = address_i[IDX_W+off-1:off]; tag = the remaining upper bits. Each line stores a valid bit, the tag and one data word.
- The FSM has three states: IDLE, RD_MISS and WR_MEM.
- In IDLE:
  - Read hit: data_o = line data, hit_o = 1, stall_o = 0. hit_count increments. State stays IDLE.
  - Read miss: stall_o = 1, hit_o = 0. State goes to RD_MISS. miss_count increments once per miss, on this transition edge.
  - Write: stall_o = 1. State goes to WR_MEM.
  - No access: stall_o = 0, hit_o = 0, data_o = 0.
- In RD_MISS:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = the aligned address_i. stall_o = 1 until the ack.
  - In the mem_ack_i cycle: data_o = mem_rdata_i, stall_o = 0. On that edge the line is filled (valid=1, tag, data) and state returns to IDLE.
- In WR_MEM:
  - mem_req_o = 1, mem_we_o = 1, mem_wdata_o = data_i. stall_o = 1 until the ack.
  - In the ack cycle: stall_o = 0. If the line currently hits, its data is updated with data_i on that edge. A write miss does not allocate. State returns to IDLE.
- mem_req_o stays high continuously until mem_ack_i; the request fields are stable throughout.
- mem_ack_i outside RD_MISS/WR_MEM is ignored.
- Counters wrap modulo 2**CNT_W.

## Timing
- Reset values:
  - State IDLE, all valid bits 0, both counters 0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - stall_o reflects the combinational decode, so it is 0 with row_i=00.
- Read hit latency: 0 cycles. data_o and hit_o are combinational from address_i and the array.
- Miss or write latency: the request is issued 1 cycle after the access is presented. Stall lasts 1 + N cycles, where N is the number of cycles from mem_req_o rising to mem_ack_i, with N ≥ 1. The pipeline advances on the ack edge.
- Back-to-back accesses: a new access may be presented in the cycle after the ack and is treated as a fresh IDLE decode. A read of a line just filled hits.
- Reset asserted mid-transaction: mem_req_o drops asynchronously and the transaction is abandoned. The backing memory must discard an unacknowledged request when reset is asserted.
- Data array contents are not reset; the valid bits guard them.

## Structure
- Package mem_pkg holds:
  - Access-code constants ROW_NONE=2'b00, ROW_READ=2'b01, ROW_WRITE=2'b10.
  - The FSM state enum (IDLE, RD_MISS, WR_MEM).
- One sub-module, cache_line_array (parameters IDX_W, TAG_W, DATA_W):
  - Asynchronous read port: valid, tag, data.
  - Synchronous write port: index, tag, data, set_valid.
  - Async-reset clear of the valid bits.
- The FSM, counters and memory port live in mem_cache_ctrl.

## Test plan
- Cold read: reset, then read 0x40 with memory ack after 3 cycles and rdata 0xDEADBEEF → stall_o high for 4 cycles, data_o=0xDEADBEEF in the ack cycle, miss_count=1.
- Read hit: repeat the read of 0x40 → stall_o=0, hit_o=1, data_o=0xDEADBEEF in the same cycle, hit_count=1, no mem_req_o.
- Write hit updates the line: write 0x12345678 to 0x40 (ack after 1 cycle), then read 0x40 → data_o=0x12345678 with zero stall.
- Write miss, no allocate: write to 0x80, then read 0x80 → miss; mem_req_o with mem_we_o=0 and mem_addr_o=0x80.
- Conflict: with IDX_W=4, fill 0x40 and then read 0x440 (same index, different tag) → miss; a subsequent read of 0x40 misses again.
- Reset mid-miss: assert reset while in RD_MISS → mem_req_o=0 immediately; after release, a read of 0x40 misses and both counters restart from 0.
